// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexes DIGITS hex digits onto a 7-segment display.
// Active-low anodes, cathodes and decimal point. A dark gap of BLANK_CYCLES
// clocks follows every digit switch to suppress ghosting. The display value is
// captured once per full frame so a digit never tears mid-frame.
// Optional build macro: SEG_LZ_BLANK_EN (leading-zero suppression).
module seg_scan_driver #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  seg_tick,
  input  logic [4*DIGITS-1:0]   digits,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int unsigned IW = $clog2(DIGITS);
  localparam int unsigned DW = 4 * DIGITS;
  localparam int unsigned CW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  localparam logic [CW-1:0] CNT_RELOAD = (BLANK_CYCLES == 0) ? '0 : CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [6:0]    SEG_OFF    = 7'h7F;

  typedef enum logic {
    ST_GHOST = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [IW-1:0]     idx, idx_nxt;
  logic [DW-1:0]     sh_dig, sh_dig_nxt;
  logic [DIGITS-1:0] sh_dp, sh_dp_nxt;
  logic [DIGITS-1:0] sh_blank, sh_blank_nxt;
  logic [DIGITS-1:0] an_nxt;
  logic [6:0]        seg_nxt;
  logic              dp_nxt;

  logic [DIGITS-1:0] lz;
  logic [3:0]        cur_nib;
  logic [IW-1:0]     idx_inc;
  logic [DIGITS-1:0] show_an;
  logic [6:0]        show_seg;
  logic              show_dp;

  // Hex to active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

`ifdef SEG_LZ_BLANK_EN
  // Leading-zero mask: digit k is dark when it and every higher digit are zero (never digit 0)
  always_comb begin
    logic run;
    lz  = '0;
    run = 1'b1;
    for (int k = int'(DIGITS) - 1; k > 0; k--) begin
      run   = run & (sh_dig[4*k +: 4] == 4'h0);
      lz[k] = run;
    end
  end
`else
  // Zeros are always displayed
  assign lz = '0;
`endif

  // Display pattern for the digit currently selected by idx
  always_comb begin
    cur_nib  = sh_dig[{idx, 2'b00} +: 4];
    show_an  = ~(DIGITS'(1) << idx);
    show_seg = (sh_blank[idx] | lz[idx]) ? SEG_OFF : hex7(cur_nib);
    show_dp  = sh_blank[idx] | ~sh_dp[idx];
  end

  // Next digit index with wrap to 0
  always_comb begin
    idx_inc = (idx == IDX_LAST) ? '0 : idx + IW'(1);
  end

  // State, counter, index, shadow and output registers
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= ST_GHOST;
      cnt      <= CNT_RELOAD;
      idx      <= '0;
      sh_dig   <= '0;
      sh_dp    <= '0;
      sh_blank <= '0;
      an       <= '1;
      seg      <= SEG_OFF;
      dp       <= 1'b1;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      sh_dig   <= sh_dig_nxt;
      sh_dp    <= sh_dp_nxt;
      sh_blank <= sh_blank_nxt;
      an       <= an_nxt;
      seg      <= seg_nxt;
      dp       <= dp_nxt;
    end
  end

  // Next-state and next-output logic; outputs default to dark
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    idx_nxt      = idx;
    sh_dig_nxt   = sh_dig;
    sh_dp_nxt    = sh_dp;
    sh_blank_nxt = sh_blank;
    an_nxt       = '1;
    seg_nxt      = SEG_OFF;
    dp_nxt       = 1'b1;

    case (state)
      ST_GHOST: begin
        // Ticks are ignored here; the gap simply runs out
        if (cnt == '0) begin
          state_nxt = ST_SHOW;
          an_nxt    = show_an;
          seg_nxt   = show_seg;
          dp_nxt    = show_dp;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      ST_SHOW: begin
        if (seg_tick) begin
          state_nxt = ST_GHOST;
          cnt_nxt   = CNT_RELOAD;
          idx_nxt   = idx_inc;
          // Frame boundary: capture the new display value
          if (idx == IDX_LAST) begin
            sh_dig_nxt   = digits;
            sh_dp_nxt    = dp_in;
            sh_blank_nxt = blank_in;
          end
        end else begin
          an_nxt  = show_an;
          seg_nxt = show_seg;
          dp_nxt  = show_dp;
        end
      end
      default: begin
        state_nxt = ST_GHOST;
        cnt_nxt   = CNT_RELOAD;
      end
    endcase
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with DIGITS=4, BLANK_CYCLES=4.
module tb_seg_scan_driver;

  logic        clk;
  logic        clr_n;
  logic        seg_tick;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int n_checks;
  int n_errors;

  seg_scan_driver #(
    .DIGITS       (4),
    .BLANK_CYCLES (4)
  ) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .seg_tick (seg_tick),
    .digits   (digits),
    .dp_in    (dp_in),
    .blank_in (blank_in),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Count dark samples (an all ones) starting at the current negedge, bounded
  task automatic wait_show(output int dark);
    dark = 0;
    while (an == 4'hF && dark < 50) begin
      dark++;
      @(negedge clk);
    end
  endtask

  // Dwell in SHOW, pulse one tick, then check gap length and the new digit
  task automatic step(input string tag, input logic [3:0] ean, input logic [6:0] eseg,
                      input logic edp);
    int d;
    repeat (100) @(negedge clk);
    seg_tick = 1'b1;
    @(negedge clk);
    seg_tick = 1'b0;
    wait_show(d);
    check({tag, "_gap"}, 32'(d), 32'd4);
    check({tag, "_an"},  32'(an),  32'(ean));
    check({tag, "_seg"}, 32'(seg), 32'(eseg));
    check({tag, "_dp"},  32'(dp),  32'(edp));
  endtask

  initial begin
    int d;
    logic [6:0] lz_seg;
    n_checks = 0;
    n_errors = 0;
    clr_n    = 1'b0;
    seg_tick = 1'b0;
    digits   = 16'h0000;
    dp_in    = 4'h0;
    blank_in = 4'h0;

    // Reset: dark outputs
    repeat (5) @(negedge clk);
    check("rst_an",  32'(an),  32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp",  32'(dp),  32'h1);

    // Release: 4 dark cycles then digit 0 of shadow "0000"
    clr_n = 1'b1;
    wait_show(d);
    check("rel_gap", 32'(d), 32'd4);
    check("rel_an",  32'(an),  32'hE);
    check("rel_seg", 32'(seg), 32'h40);
    check("rel_dp",  32'(dp),  32'h1);

    // Frame load: finish the zero frame, then scan 12AF
    digits = 16'h12AF;
    step("z1", 4'hD, 7'h40, 1'b1);
    step("z2", 4'hB, 7'h40, 1'b1);
    step("z3", 4'h7, 7'h40, 1'b1);
    step("f0", 4'hE, 7'h0E, 1'b1);
    step("f1", 4'hD, 7'h08, 1'b1);
    step("f2", 4'hB, 7'h24, 1'b1);
    step("f3", 4'h7, 7'h79, 1'b1);

    // Tearing: 1111 captured, changed to 2222 at idx 2
    digits = 16'h1111;
    step("t0", 4'hE, 7'h79, 1'b1);
    step("t1", 4'hD, 7'h79, 1'b1);
    step("t2", 4'hB, 7'h79, 1'b1);
    digits = 16'h2222;
    step("t3", 4'h7, 7'h79, 1'b1);
    step("t4", 4'hE, 7'h24, 1'b1);

    // Blank/dp: requests take effect only from the next frame
    blank_in = 4'b0100;
    dp_in    = 4'b0010;
    step("b1", 4'hD, 7'h24, 1'b1);
    step("b2", 4'hB, 7'h24, 1'b1);
    step("b3", 4'h7, 7'h24, 1'b1);
    step("b4", 4'hE, 7'h24, 1'b1);
    step("b5", 4'hD, 7'h24, 1'b0);
    step("b6", 4'hB, 7'h7F, 1'b1);
    step("b7", 4'h7, 7'h24, 1'b1);

    // Tick during gap: second tick 2 cycles after the first is dropped
    blank_in = 4'b0000;
    dp_in    = 4'b1000;
    digits   = 16'h0050;
    repeat (100) @(negedge clk);
    seg_tick = 1'b1;
    @(negedge clk);
    seg_tick = 1'b0;
    @(negedge clk);
    seg_tick = 1'b1;
    @(negedge clk);
    seg_tick = 1'b0;
    wait_show(d);
    check("gt_bound", 32'(d < 50), 32'h1);
    check("gt_an",  32'(an),  32'hE);
    check("gt_seg", 32'(seg), 32'h40);
    repeat (20) @(negedge clk);
    check("gt_hold_an", 32'(an), 32'hE);

    // Leading-zero handling of 0050 (dp request on digit 3 still honoured)
`ifdef SEG_LZ_BLANK_EN
    lz_seg = 7'h7F;
`else
    lz_seg = 7'h40;
`endif
    step("lz1", 4'hD, 7'h12, 1'b1);
    step("lz2", 4'hB, lz_seg, 1'b1);
    step("lz3", 4'h7, lz_seg, 1'b0);

    // Mid-scan reset: immediate dark, restart on shadow "0000"
    @(negedge clk);
    clr_n = 1'b0;
    #1;
    check("mr_an",  32'(an),  32'hF);
    check("mr_seg", 32'(seg), 32'h7F);
    check("mr_dp",  32'(dp),  32'h1);
    @(negedge clk);
    clr_n = 1'b1;
    wait_show(d);
    check("mr_gap", 32'(d), 32'd4);
    check("mr_an2", 32'(an),  32'hE);
    check("mr_seg2", 32'(seg), 32'h40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
